uart_cmd_framer: RTL and testbench
==================================

# uart_cmd_framer

Host-side command framer that turns one parallel command request into the byte sequence the system controller decodes from the UART receive path. It sits directly upstream of the system's UART input: its byte stream feeds a UART transmit serializer, and that serializer drives the system's RX_IN pin. It runs on one clock. It buffers one command, emits 2–4 bytes under a valid/ready handshake, and enforces a programmable inter-frame gap.

## Interface
Parameters:
- DATA_WIDTH, 8, byte and operand width; fixed at 8 for frame compatibility
- ADDR_WIDTH, 4, register-file address width
- ALU_FUN_WIDTH, 4, ALU function code width
- GAP_CYCLES, 16, idle cycles inserted after each frame (0 allowed); counter width is $clog2(GAP_CYCLES+1), minimum 1

Ports:
- i_CLK  in  1  block clock
- i_RST  in  1  reset; **asynchronous, active-high**
- i_CMD_VALID  in  1  command request
- i_CMD_TYPE  in  2  0=REG_WR, 1=REG_RD, 2=ALU_OP (with operands), 3=ALU_NOP (no operands)
- i_ADDR  in  ADDR_WIDTH  register address
- i_DATA_A  in  DATA_WIDTH  write data (REG_WR) or operand A (ALU_OP)
- i_DATA_B  in  DATA_WIDTH  operand B (ALU_OP)
- i_ALU_FUN  in  ALU_FUN_WIDTH  ALU function
- o_CMD_READY  out  1  command accepted when high together with i_CMD_VALID
- o_BYTE  out  DATA_WIDTH  byte to the serializer
- o_BYTE_VALID  out  1  o_BYTE is valid
- i_BYTE_READY  in  1  serializer accepts the byte
- o_BUSY  out  1  a frame or gap is in progress
- o_FRAME_DONE  out  1  one-cycle pulse when the last byte of a frame is accepted
- o_FRAME_CNT  out  8  count of completed frames; wraps 255→0

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - o_CMD_READY=1.
  - On i_CMD_VALID, capture type, address, operands and function into internal registers.
  - Load byte index 0 and length: REG_WR=3, REG_RD=2, ALU_OP=4, ALU_NOP=2.
  - Go to SEND.
- Frame byte sequences (index 0 first):
  - REG_WR: 0xAA, addr, data_A
  - REG_RD: 0xBB, addr
  - ALU_OP: 0xCC, data_A, data_B, fun
  - ALU_NOP: 0xDD, fun
- addr and fun are zero-extended to 8 bits.
- SEND:
  - o_BYTE_VALID=1 and o_BYTE = sequence[index].
  - When i_BYTE_READY=1 at a clock edge, the byte is transferred:
    - If index < length-1: index increments.
    - If index = length-1: o_FRAME_DONE pulses and o_FRAME_CNT increments. Go to GAP when GAP_CYCLES>0, otherwise to IDLE.
- GAP:
  - The gap counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
  - o_BYTE_VALID=0 and o_CMD_READY=0 throughout.
- o_BUSY=1 in SEND and GAP.
- Command inputs are ignored outside IDLE. A request held during SEND or GAP is accepted on the first IDLE cycle.
- Mid-frame reset: the frame is abandoned, with no partial completion, and all outputs return to reset values immediately.

## Timing
- All outputs are registered or decoded from state registers only. There is no combinational path from i_BYTE_READY or i_CMD_VALID to any output.
- Reset values:
  - state=IDLE
  - o_CMD_READY=1
  - o_BYTE=0x00, o_BYTE_VALID=0
  - o_BUSY=0, o_FRAME_DONE=0
  - o_FRAME_CNT=0x00
- Latency and throughput:
  - Command accepted at edge N → first byte valid from cycle N+1.
  - With i_BYTE_READY held high, one byte transfers per cycle. A 4-byte frame occupies SEND for exactly 4 cycles.
- Gap and re-acceptance:
  - o_FRAME_DONE is high in the cycle after the final transfer edge.
  - GAP lasts exactly GAP_CYCLES cycles.
  - o_CMD_READY returns high on the cycle after GAP ends.
  - Minimum edge-to-edge spacing between command acceptances = length + GAP_CYCLES + 1 cycles.
- Backpressure:
  - While o_BYTE_VALID=1 and i_BYTE_READY=0, o_BYTE stays stable and the index does not change.
  - o_BYTE_VALID never drops before the byte is transferred.
- Operand capture: captured operands are immune to changes on the input ports after acceptance.

## Test plan
- **Reset state:** assert i_RST asynchronously, mid-cycle → all outputs at reset values with no clock edge; o_CMD_READY=1 after release.
- **REG_WR with gap:** REG_WR addr=0x5, data=0x3C, i_BYTE_READY=1, GAP_CYCLES=16 → bytes AA,05,3C on 3 consecutive cycles; o_FRAME_DONE one pulse; o_FRAME_CNT=1; o_CMD_READY low for exactly 16 gap cycles plus frame.
- **ALU_OP under backpressure:** ALU_OP A=0x12, B=0x34, fun=0x2, with i_BYTE_READY toggled 1-0-0-1-1-0-1 → bytes CC,12,34,02 each held stable while not ready; operand input changes after acceptance are not reflected.
- **Short frames, no gap:** REG_RD addr=0xF then ALU_NOP fun=0x8 back-to-back, GAP_CYCLES=0 → BB,0F then DD,08; second command accepted on the first IDLE cycle after the first frame.
- **Mid-frame reset:** reset asserted after the second byte of an ALU_OP frame → o_BYTE_VALID=0 immediately; o_FRAME_CNT=0; next command starts a fresh frame with header 0xCC/0xAA/0xBB/0xDD.
- **Counter wrap:** 256 ALU_NOP frames → o_FRAME_CNT wraps to 0x00 on the 256th o_FRAME_DONE.

Source files
------------

// File: rtl/uart_cmd_framer_if.sv
// Command-request and byte-stream handshake bundle for uart_cmd_framer.
// master = command source / serializer side, slave = the framer.
interface uart_cmd_framer_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_FUN_WIDTH = 4
);
  logic                     i_CMD_VALID;
  logic [1:0]               i_CMD_TYPE;
  logic [ADDR_WIDTH-1:0]    i_ADDR;
  logic [DATA_WIDTH-1:0]    i_DATA_A;
  logic [DATA_WIDTH-1:0]    i_DATA_B;
  logic [ALU_FUN_WIDTH-1:0] i_ALU_FUN;
  logic                     o_CMD_READY;
  logic [DATA_WIDTH-1:0]    o_BYTE;
  logic                     o_BYTE_VALID;
  logic                     i_BYTE_READY;
  logic                     o_BUSY;
  logic                     o_FRAME_DONE;
  logic [7:0]               o_FRAME_CNT;

  modport master (
    output i_CMD_VALID, i_CMD_TYPE, i_ADDR, i_DATA_A, i_DATA_B, i_ALU_FUN, i_BYTE_READY,
    input  o_CMD_READY, o_BYTE, o_BYTE_VALID, o_BUSY, o_FRAME_DONE, o_FRAME_CNT
  );

  modport slave (
    input  i_CMD_VALID, i_CMD_TYPE, i_ADDR, i_DATA_A, i_DATA_B, i_ALU_FUN, i_BYTE_READY,
    output o_CMD_READY, o_BYTE, o_BYTE_VALID, o_BUSY, o_FRAME_DONE, o_FRAME_CNT
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// Buffers one command and emits its 2-4 byte UART frame under valid/ready,
// followed by a programmable idle gap before the next command is taken.
module uart_cmd_framer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_FUN_WIDTH = 4,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  uart_cmd_framer_if.slave bus
);
  localparam int unsigned GAP_W = (GAP_CYCLES != 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] T_REG_WR  = 2'd0;
  localparam logic [1:0] T_REG_RD  = 2'd1;
  localparam logic [1:0] T_ALU_OP  = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                   state;
  logic [1:0]               cmd_type;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_a_q;
  logic [DATA_WIDTH-1:0]    data_b_q;
  logic [ALU_FUN_WIDTH-1:0] fun_q;
  logic [1:0]               idx;
  logic [1:0]               last_idx;
  logic [GAP_W-1:0]         gap_cnt;

  // Byte i of the frame for command type t; addr/fun zero-extended.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]               t,
    input logic [1:0]               i,
    input logic [ADDR_WIDTH-1:0]    ad,
    input logic [DATA_WIDTH-1:0]    a,
    input logic [DATA_WIDTH-1:0]    b,
    input logic [ALU_FUN_WIDTH-1:0] f
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (t)
      T_REG_WR: case (i)
        2'd0:    r = DATA_WIDTH'(8'hAA);
        2'd1:    r = DATA_WIDTH'(ad);
        default: r = a;
      endcase
      T_REG_RD: r = (i == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(ad);
      T_ALU_OP: case (i)
        2'd0:    r = DATA_WIDTH'(8'hCC);
        2'd1:    r = a;
        2'd2:    r = b;
        default: r = DATA_WIDTH'(f);
      endcase
      default:  r = (i == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(f);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] frame_last(input logic [1:0] t);
    logic [1:0] r;
    case (t)
      T_REG_WR: r = 2'd2;
      T_ALU_OP: r = 2'd3;
      default:  r = 2'd1;
    endcase
    return r;
  endfunction

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state            <= IDLE;
      cmd_type         <= '0;
      addr_q           <= '0;
      data_a_q         <= '0;
      data_b_q         <= '0;
      fun_q            <= '0;
      idx              <= '0;
      last_idx         <= '0;
      gap_cnt          <= '0;
      bus.o_CMD_READY  <= 1'b1;
      bus.o_BYTE       <= '0;
      bus.o_BYTE_VALID <= 1'b0;
      bus.o_BUSY       <= 1'b0;
      bus.o_FRAME_DONE <= 1'b0;
      bus.o_FRAME_CNT  <= '0;
    end else begin
      bus.o_FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_CMD_VALID) begin
            cmd_type         <= bus.i_CMD_TYPE;
            addr_q           <= bus.i_ADDR;
            data_a_q         <= bus.i_DATA_A;
            data_b_q         <= bus.i_DATA_B;
            fun_q            <= bus.i_ALU_FUN;
            idx              <= 2'd0;
            last_idx         <= frame_last(bus.i_CMD_TYPE);
            bus.o_BYTE       <= frame_byte(bus.i_CMD_TYPE, 2'd0, bus.i_ADDR,
                                           bus.i_DATA_A, bus.i_DATA_B, bus.i_ALU_FUN);
            bus.o_BYTE_VALID <= 1'b1;
            bus.o_CMD_READY  <= 1'b0;
            bus.o_BUSY       <= 1'b1;
            state            <= SEND;
          end
        end
        SEND: begin
          if (bus.i_BYTE_READY) begin
            if (idx == last_idx) begin
              bus.o_BYTE_VALID <= 1'b0;
              bus.o_BYTE       <= '0;
              bus.o_FRAME_DONE <= 1'b1;
              bus.o_FRAME_CNT  <= bus.o_FRAME_CNT + 8'd1;
              if (GAP_CYCLES != 0) begin
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                state   <= GAP;
              end else begin
                bus.o_CMD_READY <= 1'b1;
                bus.o_BUSY      <= 1'b0;
                state           <= IDLE;
              end
            end else begin
              idx        <= idx + 2'd1;
              bus.o_BYTE <= frame_byte(cmd_type, idx + 2'd1, addr_q, data_a_q, data_b_q, fun_q);
            end
          end
        end
        GAP: begin
          // Counter runs GAP_CYCLES-1 down to 0, one state cycle per count.
          if (gap_cnt == '0) begin
            bus.o_CMD_READY <= 1'b1;
            bus.o_BUSY      <= 1'b0;
            state           <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: vector table, timing sequences,
// randomized commands against a frame-level reference model, counter wrap.
`timescale 1ns/1ps
module tb_uart_cmd_framer;
  localparam int unsigned GAP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_framer_if bus  ();
  uart_cmd_framer_if bus0 ();

  uart_cmd_framer #(.GAP_CYCLES(GAP)) dut  (.i_CLK(clk), .i_RST(rst), .bus(bus.slave));
  uart_cmd_framer #(.GAP_CYCLES(0))   dut0 (.i_CLK(clk), .i_RST(rst), .bus(bus0.slave));

  typedef struct packed {
    logic [1:0]  t;
    logic [3:0]  ad;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  f;
    logic [2:0]  len;
    logic [31:0] eb;   // expected bytes, byte 0 in [31:24]
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int total = 0, bad = 0, cyc = 0, frames = 0, done_cnt = 0, done_cnt0 = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pb = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte/frame monitor mid-cycle; also checks that a stalled byte is held.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (bus.o_BYTE_VALID && bus.i_BYTE_READY) got_q.push_back(bus.o_BYTE);
      if (bus.o_FRAME_DONE)  done_cnt++;
      if (bus0.o_FRAME_DONE) done_cnt0++;
      if (pv && !pr) begin
        check("stall_valid_held", 32'(bus.o_BYTE_VALID), 32'd1);
        check("stall_byte_held", 32'(bus.o_BYTE), 32'(pb));
      end
      pv = bus.o_BYTE_VALID;
      pr = bus.i_BYTE_READY;
      pb = bus.o_BYTE;
    end
  end

  // Reference model: the frame a command must produce, straight from the byte table.
  task automatic model_push(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] f);
    case (t)
      2'd0:    begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, ad}); exp_q.push_back(a); end
      2'd1:    begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, ad}); end
      2'd2:    begin exp_q.push_back(8'hCC); exp_q.push_back(a); exp_q.push_back(b);
                     exp_q.push_back({4'h0, f}); end
      default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); end
    endcase
  endtask

  task automatic step(input int rdy_pct);
    bus.i_BYTE_READY = ($urandom_range(99) < 32'(rdy_pct));
    @(posedge clk); #1;
  endtask

  task automatic scramble();
    bus.i_CMD_TYPE = 2'($urandom);
    bus.i_ADDR     = 4'($urandom);
    bus.i_DATA_A   = 8'($urandom);
    bus.i_DATA_B   = 8'($urandom);
    bus.i_ALU_FUN  = 4'($urandom);
  endtask

  // Present a command, wait (bounded) for acceptance, then scramble the inputs.
  task automatic send_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] f, input int rdy_pct,
                          output int acc);
    int n = 0;
    bus.i_CMD_VALID = 1'b1;
    bus.i_CMD_TYPE  = t;
    bus.i_ADDR      = ad;
    bus.i_DATA_A    = a;
    bus.i_DATA_B    = b;
    bus.i_ALU_FUN   = f;
    while (!bus.o_CMD_READY && n < 200) begin step(rdy_pct); n++; end
    check("cmd_ready_within_bound", 32'(bus.o_CMD_READY), 32'd1);
    acc = cyc + 1;
    step(rdy_pct);
    bus.i_CMD_VALID = 1'b0;
    scramble();
    frames++;
  endtask

  task automatic drain(input int rdy_pct);
    int n = 0;
    while ((bus.o_BUSY || got_q.size() < exp_q.size()) && n < 3000) begin step(rdy_pct); n++; end
    check("drain_within_bound", 32'(bus.o_BUSY), 32'd0);
    bus.i_BYTE_READY = 1'b1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, lo, bs, n;
    logic [23:0] wr_exp;
    logic [55:0] bp_exp;
    logic [6:0]  bp_pat;
    logic [31:0] e;

    tbl[0] = '{t:2'd0, ad:4'h5, a:8'h3C, b:8'h00, f:4'h0, len:3'd3, eb:32'hAA053C00};
    tbl[1] = '{t:2'd1, ad:4'hF, a:8'h00, b:8'h00, f:4'h0, len:3'd2, eb:32'hBB0F0000};
    tbl[2] = '{t:2'd2, ad:4'h0, a:8'h12, b:8'h34, f:4'h2, len:3'd4, eb:32'hCC123402};
    tbl[3] = '{t:2'd3, ad:4'h0, a:8'h00, b:8'h00, f:4'h8, len:3'd2, eb:32'hDD080000};
    tbl[4] = '{t:2'd0, ad:4'h0, a:8'hFF, b:8'h00, f:4'h0, len:3'd3, eb:32'hAA00FF00};
    tbl[5] = '{t:2'd2, ad:4'h0, a:8'h00, b:8'hFF, f:4'hF, len:3'd4, eb:32'hCC00FF0F};

    bus.i_CMD_VALID = 1'b0;  bus.i_BYTE_READY = 1'b1;  scramble();
    bus0.i_CMD_VALID = 1'b0; bus0.i_BYTE_READY = 1'b1;
    bus0.i_CMD_TYPE = 2'd0;  bus0.i_ADDR = 4'h0; bus0.i_DATA_A = 8'h00;
    bus0.i_DATA_B = 8'h00;   bus0.i_ALU_FUN = 4'h0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_cmd_ready", 32'(bus.o_CMD_READY), 32'd1);
    check("rst_byte", 32'(bus.o_BYTE), 32'h00);
    check("rst_byte_valid", 32'(bus.o_BYTE_VALID), 32'd0);
    check("rst_busy", 32'(bus.o_BUSY), 32'd0);
    check("rst_frame_done", 32'(bus.o_FRAME_DONE), 32'd0);
    check("rst_frame_cnt", 32'(bus.o_FRAME_CNT), 32'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(bus.o_CMD_READY), 32'd1);

    // Vector table, valid held back-to-back, serializer always ready
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].t, tbl[i].ad, tbl[i].a, tbl[i].b, tbl[i].f, 100, acc);
      e = tbl[i].eb;
      for (int j = 0; j < int'(tbl[i].len); j++) exp_q.push_back(e[31-8*j -: 8]);
      if (i > 0) check("tbl_accept_spacing", 32'(acc - prev_acc), 32'(int'(tbl[i-1].len) + GAP + 1));
      prev_acc = acc;
    end
    drain(100);
    compare_q("tbl");
    check("tbl_frame_cnt", 32'(bus.o_FRAME_CNT), 32'(frames));

    // REG_WR frame timing including the gap
    wr_exp = 24'hAA053C;
    n = done_cnt;
    send_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 100, acc);
    lo = 1; bs = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 3) begin
        check("wr_valid", 32'(bus.o_BYTE_VALID), 32'd1);
        check("wr_byte", 32'(bus.o_BYTE), 32'(wr_exp[23-8*k -: 8]));
      end
      if (k == 3) begin
        check("wr_done_pulse", 32'(bus.o_FRAME_DONE), 32'd1);
        check("wr_valid_off", 32'(bus.o_BYTE_VALID), 32'd0);
        check("wr_frame_cnt", 32'(bus.o_FRAME_CNT), 32'(frames));
      end
      lo += int'(!bus.o_CMD_READY);
      bs += int'(bus.o_BUSY);
      step(100);
    end
    check("wr_ready_low_cycles", 32'(lo), 32'(3 + GAP + 1));
    check("wr_busy_cycles", 32'(bs), 32'(3 + GAP));
    check("wr_done_count", 32'(done_cnt - n), 32'd1);
    got_q.delete();

    // ALU_OP under backpressure; inputs scrambled right after acceptance
    bp_exp = 56'hCC121212340202;
    bp_pat = 7'b1011001;
    send_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 100, acc);
    for (int k = 0; k < 7; k++) begin
      bus.i_BYTE_READY = bp_pat[k];
      check("bp_valid", 32'(bus.o_BYTE_VALID), 32'd1);
      check("bp_byte", 32'(bus.o_BYTE), 32'(bp_exp[55-8*k -: 8]));
      scramble();
      @(posedge clk); #1;
    end
    check("bp_done_pulse", 32'(bus.o_FRAME_DONE), 32'd1);
    check("bp_frame_cnt", 32'(bus.o_FRAME_CNT), 32'(frames));
    bus.i_BYTE_READY = 1'b1;
    drain(100);
    exp_q.push_back(8'hCC); exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h02);
    compare_q("bp");

    // No-gap instance: REG_RD then ALU_NOP back-to-back
    bus0.i_CMD_VALID = 1'b1; bus0.i_CMD_TYPE = 2'd1; bus0.i_ADDR = 4'hF;
    check("g0_ready_idle", 32'(bus0.o_CMD_READY), 32'd1);
    @(posedge clk); #1;
    bus0.i_CMD_TYPE = 2'd3; bus0.i_ALU_FUN = 4'h8; bus0.i_ADDR = 4'h1;
    check("g0_b0", 32'(bus0.o_BYTE), 32'hBB);
    check("g0_v0", 32'(bus0.o_BYTE_VALID), 32'd1);
    @(posedge clk); #1;
    check("g0_b1", 32'(bus0.o_BYTE), 32'h0F);
    @(posedge clk); #1;
    check("g0_done1", 32'(bus0.o_FRAME_DONE), 32'd1);
    check("g0_ready_back", 32'(bus0.o_CMD_READY), 32'd1);
    check("g0_valid_off", 32'(bus0.o_BYTE_VALID), 32'd0);
    @(posedge clk); #1;
    bus0.i_CMD_VALID = 1'b0;
    check("g0_b2", 32'(bus0.o_BYTE), 32'hDD);
    check("g0_ready_low", 32'(bus0.o_CMD_READY), 32'd0);
    @(posedge clk); #1;
    check("g0_b3", 32'(bus0.o_BYTE), 32'h08);
    @(posedge clk); #1;
    check("g0_done2", 32'(bus0.o_FRAME_DONE), 32'd1);
    check("g0_frame_cnt", 32'(bus0.o_FRAME_CNT), 32'd2);

    // Mid-frame reset after two ALU_OP bytes transferred
    send_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 100, acc);
    step(100);
    step(100);
    check("mr_third_byte", 32'(bus.o_BYTE), 32'h34);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", 32'(bus.o_BYTE_VALID), 32'd0);
    check("mr_byte", 32'(bus.o_BYTE), 32'h00);
    check("mr_busy", 32'(bus.o_BUSY), 32'd0);
    check("mr_done", 32'(bus.o_FRAME_DONE), 32'd0);
    check("mr_frame_cnt", 32'(bus.o_FRAME_CNT), 32'h00);
    check("mr_cmd_ready", 32'(bus.o_CMD_READY), 32'd1);
    check("mr_frame_cnt0", 32'(bus0.o_FRAME_CNT), 32'h00);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("mr_no_resume", 32'(bus.o_BYTE_VALID), 32'd0);
    got_q.delete(); exp_q.delete();
    frames = 0;
    send_cmd(2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 100, acc);
    check("mr_fresh_header", 32'(bus.o_BYTE), 32'hBB);
    model_push(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
    drain(100);
    compare_q("mr");

    // Randomized commands and backpressure against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] t; logic [3:0] ad; logic [7:0] a; logic [7:0] b; logic [3:0] f;
      t = 2'($urandom); ad = 4'($urandom); a = 8'($urandom); b = 8'($urandom); f = 4'($urandom);
      send_cmd(t, ad, a, b, f, 60, acc);
      model_push(t, ad, a, b, f);
    end
    drain(60);
    compare_q("rand");
    check("rand_frame_cnt", 32'(bus.o_FRAME_CNT), 32'(frames & 255));

    // Frame counter wrap on the no-gap instance
    bus0.i_CMD_VALID = 1'b1; bus0.i_CMD_TYPE = 2'd3; bus0.i_ALU_FUN = 4'h8;
    n = 0; lo = 0;
    while (n < 255 && lo < 2000) begin
      @(posedge clk); #1;
      lo++;
      if (bus0.o_FRAME_DONE) n++;
      if (n == 255) bus0.i_CMD_VALID = 1'b0;
    end
    check("wrap_255_frames_seen", 32'(n), 32'd255);
    check("wrap_cnt_255", 32'(bus0.o_FRAME_CNT), 32'd255);
    @(posedge clk); #1;
    bus0.i_CMD_VALID = 1'b1;
    @(posedge clk); #1;
    bus0.i_CMD_VALID = 1'b0;
    lo = 0;
    while (!bus0.o_FRAME_DONE && lo < 20) begin @(posedge clk); #1; lo++; end
    check("wrap_done_256", 32'(bus0.o_FRAME_DONE), 32'd1);
    check("wrap_cnt_0", 32'(bus0.o_FRAME_CNT), 32'h00);
    @(posedge clk); #1;
    check("wrap_total_done0", 32'(done_cnt0), 32'd258);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
